mux_pipe_n: RTL and testbench

//   Parametrised successor to the 2:1 32-bit datapath mux.
//   N-input, WIDTH-bit mux with a registered output and a valid/ready handshake on every channel.
//   Two select modes: fixed (external sel) and round-robin arbitration among valid inputs.

---
 rtl/mux_pipe_n_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/mux_pipe_n.sv | 130 +++++++++++++
 tb/tb_mux_pipe_n.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pipe_n_pkg.sv
// Shared constants and helpers for the mux_pipe_n datapath mux and its arbiter.
package mux_pipe_n_pkg;

    localparam int unsigned SEL_MODE_FIXED = 0;
    localparam int unsigned SEL_MODE_RR    = 1;

    // True when a select/source index addresses an existing channel.
    function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for mux_pipe_n: grants the first requester after rr_ptr,
// and moves rr_ptr to the granted index only when the caller reports a transfer.
module rr_arbiter
    import mux_pipe_n_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  req,
    input  logic             advance,
    output logic [N_IN-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [SEL_W-1:0] rr_ptr_q;
    logic [SEL_W-1:0] rr_ptr_d;
    int unsigned      best_c;
    int unsigned      best_dist_c;
    int unsigned      dist_c;

    // Distance from rr_ptr+1 (mod N_IN); the closest requester wins.
    always_comb begin
        best_c      = 0;
        best_dist_c = N_IN;
        dist_c      = 0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            dist_c = (i + 2 * N_IN - 32'(rr_ptr_q) - 1) % N_IN;
            if (req[i] && (dist_c < best_dist_c)) begin
                best_dist_c = dist_c;
                best_c      = i;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            grant[i] = (best_dist_c < N_IN) && (best_c == i);
        end
    end

    assign grant_idx = SEL_W'(best_c);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= SEL_W'(N_IN - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mux_pipe_n.sv
// N-input registered mux with valid/ready on every channel, fixed or round-robin select.
// Optional sticky out-of-range select flag enabled by MUX_PIPE_SEL_ERR_EN.
module mux_pipe_n
    import mux_pipe_n_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_IN     = 4,
    parameter int unsigned SEL_MODE = SEL_MODE_FIXED,
    parameter int unsigned SEL_W    = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [N_IN-1:0]         in_valid,
    output logic [N_IN-1:0]         in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
`ifdef MUX_PIPE_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [SEL_W-1:0] out_src_q;
    logic [SEL_W-1:0] out_src_d;

    logic             load_c;
    logic             xfer_c;
    logic [N_IN-1:0]  grant_c;
    logic [SEL_W-1:0] gidx_c;
    logic [WIDTH-1:0] data_c;

    // The single output slot can take a beat when empty or being drained.
    assign load_c   = ~out_valid_q | out_ready;
    assign xfer_c   = (|grant_c) & load_c & rst_n;
    assign in_ready = grant_c & {N_IN{load_c & rst_n}};

    if (SEL_MODE == SEL_MODE_RR) begin : g_rr
        rr_arbiter #(
            .N_IN  (N_IN),
            .SEL_W (SEL_W)
        ) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (in_valid),
            .advance   (xfer_c),
            .grant     (grant_c),
            .grant_idx (gidx_c)
        );
    end else begin : g_fixed
        // An out-of-range sel matches no channel and so grants nothing.
        always_comb begin
            grant_c = '0;
            for (int unsigned i = 0; i < N_IN; i++) begin
                grant_c[i] = in_valid[i] && (32'(sel) == i);
            end
        end
        assign gidx_c = sel;
    end

    always_comb begin
        data_c = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant_c[i]) begin
                data_c = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load_c) begin
            out_valid_d = xfer_c;
            if (xfer_c) begin
                out_data_d = data_c;
                out_src_d  = gidx_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

`ifdef MUX_PIPE_SEL_ERR_EN
    logic sel_err_q;
    logic sel_err_d;

    // Sticky: records any attempt to select a nonexistent channel while data is offered.
    always_comb begin
        sel_err_d = sel_err_q;
        if ((SEL_MODE == SEL_MODE_FIXED) && load_c && (|in_valid)
            && !idx_in_range(32'(sel), N_IN)) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n: fixed select (N=4 and N=5) and round-robin (N=4).
// The sticky select-error checks are active when MUX_PIPE_SEL_ERR_EN is defined.
module tb_mux_pipe_n;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // u0: fixed select, N_IN=4
    logic [127:0] in_data0;
    logic [3:0]   in_valid0, in_ready0;
    logic [1:0]   sel0, out_src0;
    logic [31:0]  out_data0;
    logic         out_valid0, out_ready0;
    // u1: round-robin, N_IN=4
    logic [127:0] in_data1;
    logic [3:0]   in_valid1, in_ready1;
    logic [1:0]   sel1, out_src1;
    logic [31:0]  out_data1;
    logic         out_valid1, out_ready1;
    // u2: fixed select, N_IN=5 (sel can exceed the channel count)
    logic [159:0] in_data2;
    logic [4:0]   in_valid2, in_ready2;
    logic [2:0]   sel2, out_src2;
    logic [31:0]  out_data2;
    logic         out_valid2, out_ready2;
`ifdef MUX_PIPE_SEL_ERR_EN
    logic         sel_err0, sel_err1, sel_err2;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    mux_pipe_n #(.WIDTH(32), .N_IN(4), .SEL_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .sel(sel0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_src(out_src0)
`ifdef MUX_PIPE_SEL_ERR_EN
        , .sel_err(sel_err0)
`endif
    );

    mux_pipe_n #(.WIDTH(32), .N_IN(4), .SEL_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .sel(sel1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_src(out_src1)
`ifdef MUX_PIPE_SEL_ERR_EN
        , .sel_err(sel_err1)
`endif
    );

    mux_pipe_n #(.WIDTH(32), .N_IN(5), .SEL_MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .sel(sel2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_src(out_src2)
`ifdef MUX_PIPE_SEL_ERR_EN
        , .sel_err(sel_err2)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rr_exp [8];
        rr_exp = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd3, 4'd1};

        // Reset with every channel valid
        rst_n      = 1'b0;
        in_data0   = {32'h4444_4444, 32'hAAAA_AAAA, 32'h2222_2222, 32'h1111_1111};
        in_valid0  = 4'hF;
        sel0       = 2'd2;
        out_ready0 = 1'b1;
        in_data1   = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
        in_valid1  = 4'hF;
        sel1       = 2'd0;
        out_ready1 = 1'b1;
        in_data2   = {32'hD000_0004, 32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        in_valid2  = 5'h1F;
        sel2       = 3'd0;
        out_ready2 = 1'b1;
        step();
        step();
        chk("rst_out_valid0", 64'(out_valid0), 64'(1'b0));
        chk("rst_out_data0",  64'(out_data0),  64'(32'h0));
        chk("rst_out_src0",   64'(out_src0),   64'(2'd0));
        chk("rst_in_ready0",  64'(in_ready0),  64'(4'h0));
        chk("rst_in_ready1",  64'(in_ready1),  64'(4'h0));
        chk("rst_out_valid1", 64'(out_valid1), 64'(1'b0));

        in_valid0 = 4'h0;
        in_valid1 = 4'h0;
        in_valid2 = 5'h0;
        rst_n     = 1'b1;
        step();

        // Fixed select, channel 2
        in_valid0 = 4'b0100;
        sel0      = 2'd2;
        #1;
        chk("m0_in_ready_ch2", 64'(in_ready0), 64'(4'b0100));
        step();
        chk("m0_out_data_ch2",  64'(out_data0),  64'(32'hAAAA_AAAA));
        chk("m0_out_src_ch2",   64'(out_src0),   64'(2'd2));
        chk("m0_out_valid_ch2", 64'(out_valid0), 64'(1'b1));
        in_valid0 = 4'h0;
        step();
        chk("m0_idle_valid", 64'(out_valid0), 64'(1'b0));
        chk("m0_idle_hold",  64'(out_data0),  64'(32'hAAAA_AAAA));

        // Backpressure: hold 5555_5555 while a channel-3 beat waits
        in_data0[32 +: 32] = 32'h5555_5555;
        sel0      = 2'd1;
        in_valid0 = 4'b0010;
        step();
        chk("bp_load_data", 64'(out_data0), 64'(32'h5555_5555));
        out_ready0 = 1'b0;
        in_data0[96 +: 32] = 32'h3333_3333;
        sel0      = 2'd3;
        in_valid0 = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready0), 64'(4'h0));
            step();
            chk("bp_data_hold",  64'(out_data0),  64'(32'h5555_5555));
            chk("bp_valid_hold", 64'(out_valid0), 64'(1'b1));
            chk("bp_src_hold",   64'(out_src0),   64'(2'd1));
        end
        out_ready0 = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready0), 64'(4'b1000));
        step();
        chk("bp_release_data", 64'(out_data0), 64'(32'h3333_3333));
        chk("bp_release_src",  64'(out_src0),  64'(2'd3));

        // Back-to-back beats with sel changing every cycle
        sel0      = 2'd0;
        in_valid0 = 4'b0001;
        step();
        chk("b2b_src0",  64'(out_src0),  64'(2'd0));
        chk("b2b_data0", 64'(out_data0), 64'(32'h1111_1111));
        sel0      = 2'd2;
        in_valid0 = 4'b0100;
        step();
        chk("b2b_src2",  64'(out_src0),  64'(2'd2));
        chk("b2b_data2", 64'(out_data0), 64'(32'hAAAA_AAAA));
        in_valid0 = 4'h0;
        step();
        chk("b2b_drain", 64'(out_valid0), 64'(1'b0));

        // Round-robin: all valid, then 4'b1010
        in_valid1 = 4'hF;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) in_valid1 = 4'b1010;
            #1;
            chk("rr_in_ready", 64'(in_ready1), 64'(4'b0001 << rr_exp[k]));
            step();
            chk("rr_out_src",   64'(out_src1),   64'(rr_exp[k]));
            chk("rr_out_data",  64'(out_data1),  64'(32'hC000_0000 | 32'(rr_exp[k])));
            chk("rr_out_valid", 64'(out_valid1), 64'(1'b1));
        end

        // Round-robin stall after grant 1: pointer must not move
        in_valid1  = 4'hF;
        out_ready1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rrs_in_ready", 64'(in_ready1), 64'(4'h0));
            step();
            chk("rrs_src_hold", 64'(out_src1), 64'(2'd1));
        end
        out_ready1 = 1'b1;
        #1;
        chk("rrs_release_ready", 64'(in_ready1), 64'(4'b0100));
        step();
        chk("rrs_release_src",  64'(out_src1),  64'(2'd2));
        chk("rrs_release_data", 64'(out_data1), 64'(32'hC000_0002));
        in_valid1 = 4'h0;
        step();

        // Out-of-range select on the 5-channel instance
`ifdef MUX_PIPE_SEL_ERR_EN
        chk("serr_clear", 64'(sel_err2), 64'(1'b0));
`endif
        sel2      = 3'd5;
        in_valid2 = 5'b00001;
        #1;
        chk("oor_in_ready", 64'(in_ready2), 64'(5'h0));
        step();
        chk("oor_no_xfer", 64'(out_valid2), 64'(1'b0));
`ifdef MUX_PIPE_SEL_ERR_EN
        chk("serr_set", 64'(sel_err2), 64'(1'b1));
`endif
        sel2 = 3'd0;
        #1;
        chk("n5_in_ready0", 64'(in_ready2), 64'(5'b00001));
        step();
        chk("n5_src0",  64'(out_src2),  64'(3'd0));
        chk("n5_data0", 64'(out_data2), 64'(32'hD000_0000));
        sel2      = 3'd4;
        in_valid2 = 5'b10000;
        #1;
        chk("n5_in_ready4", 64'(in_ready2), 64'(5'b10000));
        step();
        chk("n5_src4",  64'(out_src2),  64'(3'd4));
        chk("n5_data4", 64'(out_data2), 64'(32'hD000_0004));
        in_valid2 = 5'h0;
        step();
`ifdef MUX_PIPE_SEL_ERR_EN
        chk("serr_sticky", 64'(sel_err2), 64'(1'b1));
`endif

        // Reset while a beat is held and requests are pending
        sel0      = 2'd2;
        in_valid0 = 4'b0100;
        step();
        out_ready0 = 1'b0;
        step();
        chk("mid_held", 64'(out_valid0), 64'(1'b1));
        in_valid1 = 4'hF;
        rst_n     = 1'b0;
        #1;
        chk("mid_rst_in_ready1", 64'(in_ready1), 64'(4'h0));
        step();
        chk("mid_rst_valid0", 64'(out_valid0), 64'(1'b0));
        chk("mid_rst_data0",  64'(out_data0),  64'(32'h0));
`ifdef MUX_PIPE_SEL_ERR_EN
        chk("serr_rst", 64'(sel_err2), 64'(1'b0));
`endif
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
